// File: rtl/four_input_rr_arbiter_pkg.sv
// Shared constants and state encoding for the four-input round-robin arbiter.
// HOLD_MAX_DEF is the default grant hold limit used when ARB_TIMEOUT_EN is defined.
package four_input_rr_arbiter_pkg;

  localparam int ARB_N        = 4;
  localparam int HOLD_MAX_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/four_input_rr_arbiter_rr_pick.sv
// Combinational round-robin winner search.
// The search starts at last+1 and wraps around through last itself.
module rr_pick
  import four_input_rr_arbiter_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [1:0]       last,
  output logic [1:0]       win_id,
  output logic             win_vld
);

  logic [1:0] idx;

  // Scan from the lowest priority down, so the highest-priority hit is written last.
  always_comb begin
    idx     = '0;
    win_id  = '0;
    win_vld = 1'b0;
    for (int k = ARB_N; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        win_id  = idx;
        win_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/four_input_rr_arbiter.sv
// Four-requester round-robin arbiter with registered grant and no-request flag.
// Define ARB_TIMEOUT_EN to revoke grants held for HOLD_MAX cycles.
module four_input_rr_arbiter
  import four_input_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ARB_N-1:0] req,
  output logic [ARB_N-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic             none_req,
  output logic             timeout
);

  if ((1 << CNT_W) <= HOLD_MAX) begin : g_cfg_bad
    $error("CNT_W too narrow for HOLD_MAX");
  end

  arb_state_e       state_q;
  logic [ARB_N-1:0] gnt_q;
  logic [1:0]       gnt_id_q;
  logic             busy_q;
  logic             none_q;
  logic             to_q;
  logic [1:0]       last_q;
  logic [ARB_N-1:0] mask_q;
  logic [ARB_N-1:0] elig;
  logic [1:0]       win_id;
  logic             win_vld;
  logic             expire;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [ARB_N-1:0] mask_d;

  assign expire = (state_q == ST_GRANT) && req[gnt_id_q]
                  && (cnt_q == HOLD_LAST);

  // A revoked owner stays masked until it drops its request once.
  always_comb begin
    mask_d = mask_q & req;
    if (expire) mask_d[gnt_id_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
      if (state_q == ST_IDLE) cnt_q <= '0;
      else                    cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
  assign mask_q = '0;
`endif

  assign elig = req & ~mask_q;

  rr_pick u_pick (
    .req    (elig),
    .last   (last_q),
    .win_id (win_id),
    .win_vld(win_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      none_q   <= 1'b1;
      to_q     <= 1'b0;
      last_q   <= 2'd3;
    end else begin
      none_q <= ~|req;
      to_q   <= expire;
      unique case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            state_q  <= ST_GRANT;
            gnt_q    <= 4'b0001 << win_id;
            gnt_id_q <= win_id;
            busy_q   <= 1'b1;
            last_q   <= win_id;
          end
        end
        ST_GRANT: begin
          if (!req[gnt_id_q] || expire) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;
  assign none_req = none_q;
  assign timeout  = to_q;

endmodule

// File: tb/tb_four_input_rr_arbiter.sv
// Directed bench for four_input_rr_arbiter with a cycle-level reference model.
// Honors ARB_TIMEOUT_EN the same way as the design.
module tb_four_input_rr_arbiter;

  localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       none_req;
  logic       timeout;

  logic [3:0] pk_req;
  logic [1:0] pk_last;
  logic [1:0] pk_id;
  logic       pk_vld;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  four_input_rr_arbiter #(.HOLD_MAX(HOLD), .CNT_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .none_req(none_req),
    .timeout (timeout)
  );

  rr_pick u_pick_tb (
    .req    (pk_req),
    .last   (pk_last),
    .win_id (pk_id),
    .win_vld(pk_vld)
  );

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index, pointer, masked set, cycles held.
  int       m_own  = -1;
  int       m_last = 3;
  int       m_hold = 0;
  bit [3:0] m_mask = '0;
  bit       m_to   = 1'b0;
  bit       m_none = 1'b1;
  bit       started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_own = -1; m_last = 3; m_hold = 0;
      m_mask = '0; m_to = 0; m_none = 1;
      started = 1'b1;
    end else begin
      bit [3:0] nm;
      m_none = (req == 4'b0000);
      m_to = 0;
      nm = m_mask & req;
      if (m_own < 0) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (m_own < 0 && req[c] && !m_mask[c]) begin
            m_own = c; m_last = c; m_hold = 1;
          end
        end
      end else if (!req[m_own]) begin
        m_own = -1;
      end else if (TO_EN && m_hold == HOLD) begin
        nm[m_own] = 1'b1;
        m_own = -1;
        m_to = 1;
      end else begin
        m_hold++;
      end
      m_mask = nm;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [3:0] eg;
      eg = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
      chk("model_gnt", gnt, eg);
      chk("model_busy", {3'b0, busy}, {3'b0, m_own >= 0});
      chk("model_none", {3'b0, none_req}, {3'b0, m_none});
      chk("model_to", {3'b0, timeout}, {3'b0, m_to});
      if (m_own >= 0) chk("model_id", {2'b0, gnt_id}, 4'(m_own));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] pk_tab_req  [7] = '{4'b0000, 4'b1111, 4'b1111, 4'b0101,
                                   4'b0101, 4'b1000, 4'b0010};
  logic [1:0] pk_tab_last [7] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
  logic [2:0] pk_tab_exp  [7] = '{3'b000, 3'b100, 3'b101, 3'b110,
                                   3'b100, 3'b111, 3'b101};
  logic [3:0] fair_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    pk_req = '0;
    pk_last = '0;

    // Picker standalone: {vld, id}
    for (int i = 0; i < 7; i++) begin
      pk_req = pk_tab_req[i];
      pk_last = pk_tab_last[i];
      #1;
      if (pk_tab_exp[i][2]) chk("pick", {1'b0, pk_vld, pk_id}, {1'b0, pk_tab_exp[i]});
      else chk("pick_vld", {3'b0, pk_vld}, 4'b0);
    end

    // T1 reset
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t1_gnt", gnt, 4'b0000);
      chk("t1_busy", {3'b0, busy}, 4'b0);
      chk("t1_to", {3'b0, timeout}, 4'b0);
      chk("t1_none", {3'b0, none_req}, 4'b0001);
    end
    rst = 1'b0;
    tick();
    chk("t1_first", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    chk("t1_rel", gnt, 4'b0000);

    // T2 single requester
    req = 4'b0100;
    tick();
    chk("t2_gnt", gnt, 4'b0100);
    chk("t2_id", {2'b0, gnt_id}, 4'd2);
    repeat (4) tick();
    req = 4'b0000;
    tick();
    chk("t2_rel", gnt, 4'b0000);

    // T3 fairness
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      req = 4'b1111;
      tick();
      chk("t3_order", gnt, fair_exp[n]);
      repeat (3) tick();
      req = 4'b1111 & ~fair_exp[n];
      tick();
      chk("t3_dead", gnt, 4'b0000);
    end
    req = 4'b0000;
    tick();

    // T4 none_req
    req = 4'b0000; tick(); chk("t4_a", {3'b0, none_req}, 4'd1);
    req = 4'b1000; tick(); chk("t4_b", {3'b0, none_req}, 4'd0);
    req = 4'b0000; tick(); chk("t4_c", {3'b0, none_req}, 4'd1);

    // T5 reset mid-grant
    req = 4'b1000;
    tick();
    chk("t5_own3", gnt, 4'b1000);
    req = 4'b1001;
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst", gnt, 4'b0000);
    chk("t5_busy", {3'b0, busy}, 4'b0);
    rst = 1'b0;
    tick();
    chk("t5_next", gnt, 4'b0001);

    // T6 timeout
    req = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_hold", gnt, 4'b0001);
    end
    tick();
    chk("t6_gnt", gnt, TO_EN ? 4'b0000 : 4'b0001);
    chk("t6_to", {3'b0, timeout}, {3'b0, TO_EN});
    repeat (2) begin
      tick();
      chk("t6_masked", gnt, TO_EN ? 4'b0000 : 4'b0001);
      chk("t6_to_lo", {3'b0, timeout}, 4'b0);
    end
    req = 4'b0000;
    tick();
    req = 4'b0001;
    tick();
    chk("t6_regrant", gnt, 4'b0001);
    req = 4'b0000;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
